// File: rtl/sdram_host_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller host port among NUM_REQ clients.
// Optional build macro SDRAM_ARB_PRIO0_EN gives requester 0 absolute priority.
module sdram_host_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    rq_req,
    input  logic [NUM_REQ*25-1:0] rq_addr,
    input  logic [NUM_REQ*16-1:0] rq_wdata,
    input  logic [NUM_REQ-1:0]    rq_wr_en,
    input  logic [NUM_REQ*2-1:0]  rq_bytesel,
    output logic [NUM_REQ-1:0]    rq_gnt,
    output logic [NUM_REQ-1:0]    rq_done,
    output logic [15:0]           rq_rdata,
    output logic [25:1]           h_addr,
    output logic [15:0]           h_wdata,
    output logic                  h_wr_en,
    output logic [1:0]            h_bytesel,
    output logic                  h_access,
    input  logic [15:0]           h_rdata,
    input  logic                  h_compl,
    input  logic                  h_config_done,
    output logic                  err_timeout,
    output logic [1:0]            dbg_state
);

    // Handshake: a requester holds rq_req and its fields until rq_gnt pulses;
    // exactly one rq_done pulse follows each grant, with rq_rdata valid alongside it.

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_num_req_check
        $error("sdram_host_arbiter: NUM_REQ must be in 2..8");
    end

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        S_WAIT_CFG = 2'd0,
        S_IDLE     = 2'd1,
        S_BUSY     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   last_q;
    logic [IW-1:0]   owner_q;
    logic [CW-1:0]   wd_cnt;

    logic            win_valid;
    logic [IW-1:0]   win_idx;
    logic            prio_hit;
    logic [IW:0]     cand;
    logic [NUM_REQ-1:0] win_onehot;
    logic [NUM_REQ-1:0] own_onehot;
    logic [24:0]     sel_addr;
    logic [15:0]     sel_wdata;
    logic            sel_wr_en;
    logic [1:0]      sel_bytesel;
    logic            grant_fire;
    logic            compl_fire;

    // Scan last+1, last+2, ... with wrap; the first requesting slot wins.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        prio_hit  = 1'b0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = {1'b0, last_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(NUM_REQ)) begin
                cand = cand - (IW+1)'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_valid && cand == (IW+1)'(j) && rq_req[j]) begin
                    win_valid = 1'b1;
                    win_idx   = IW'(j);
                end
            end
        end
`ifdef SDRAM_ARB_PRIO0_EN
        if (rq_req[0]) begin
            win_valid = 1'b1;
            win_idx   = '0;
            prio_hit  = 1'b1;
        end
`endif
    end

    always_comb begin
        sel_addr    = '0;
        sel_wdata   = '0;
        sel_wr_en   = 1'b0;
        sel_bytesel = '0;
        win_onehot  = '0;
        own_onehot  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (win_idx == IW'(j)) begin
                sel_addr      = rq_addr[j*25 +: 25];
                sel_wdata     = rq_wdata[j*16 +: 16];
                sel_wr_en     = rq_wr_en[j];
                sel_bytesel   = rq_bytesel[j*2 +: 2];
                win_onehot[j] = 1'b1;
            end
            if (owner_q == IW'(j)) begin
                own_onehot[j] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        compl_fire = 1'b0;
        case (state_q)
            S_WAIT_CFG: begin
                if (h_config_done) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (win_valid) begin
                    grant_fire = 1'b1;
                    state_d    = S_BUSY;
                end
            end
            S_BUSY: begin
                if (h_compl) begin
                    compl_fire = 1'b1;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_WAIT_CFG;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_WAIT_CFG;
        end else begin
            state_q <= state_d;
        end
    end

    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rq_gnt      <= '0;
            rq_done     <= '0;
            rq_rdata    <= '0;
            h_addr      <= '0;
            h_wdata     <= '0;
            h_wr_en     <= 1'b0;
            h_bytesel   <= '0;
            h_access    <= 1'b0;
            last_q      <= IW'(NUM_REQ - 1);
            owner_q     <= '0;
        end else begin
            rq_gnt  <= '0;
            rq_done <= '0;
            if (grant_fire) begin
                h_addr    <= sel_addr;
                h_wdata   <= sel_wdata;
                h_wr_en   <= sel_wr_en;
                h_bytesel <= sel_bytesel;
                h_access  <= 1'b1;
                rq_gnt    <= win_onehot;
                owner_q   <= win_idx;
                // A priority grant to requester 0 leaves the rotation untouched.
                if (!prio_hit) begin
                    last_q <= win_idx;
                end
            end
            if (compl_fire) begin
                h_access <= 1'b0;
                rq_rdata <= h_rdata;
                rq_done  <= own_onehot;
            end
        end
    end

    // Watchdog counts BUSY cycles and saturates at the limit; the flag is sticky.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else if (grant_fire) begin
            wd_cnt <= '0;
        end else if (state_q == S_BUSY && TIMEOUT_CYC > 0 && wd_cnt != CW'(TIMEOUT_CYC)) begin
            wd_cnt <= wd_cnt + 1'b1;
            if (wd_cnt + 1'b1 == CW'(TIMEOUT_CYC)) begin
                err_timeout <= 1'b1;
            end
        end
    end

endmodule
